payload_char_decoder: RTL and testbench

- Upstream producer for the payload match engines: turns the AXI-Stream payload into per-character-class hit lines, one byte per cycle.
- Drives each engine's character-class inputs (`char_hit[k]` feeds `in_k`) together with the shared `en` and `sod` controls.
- Sits between the packet payload extractor and the bank of engine instances.
- The class membership table is runtime-programmable, so new rule sets need no regeneration of this block.

---
 rtl/payload_char_decoder_if.sv | 22 ++
 rtl/payload_char_decoder.sv | 154 +++++++++++++++
 tb/tb_payload_char_decoder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/payload_char_decoder_if.sv
// payload_char_decoder_if: AXI-Stream payload bus feeding the character decoder.
// The master side is the payload extractor; the slave side is the decoder.
interface payload_char_decoder_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata, tkeep, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/payload_char_decoder.sv
// payload_char_decoder: serialises AXI-Stream payload words into one byte per
// cycle and looks each byte up in a programmable 256-entry class table,
// producing per-class hit lines plus en/sod/eod controls for the match engines.
// Optional build macro: PAYLOAD_DEC_NOCASE_EN folds 'A'-'Z' to 'a'-'z' before
// the table lookup (byte_out still shows the raw byte; cfg writes never fold).
module payload_char_decoder #(
    parameter int DATA_WIDTH  = 64,
    parameter int NUM_CLASSES = 21,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    payload_char_decoder_if.slave  s,
    input  logic                   cfg_we,
    input  logic [7:0]             cfg_addr,
    input  logic [NUM_CLASSES-1:0] cfg_wdata,
    output logic [NUM_CLASSES-1:0] char_hit,
    output logic                   en,
    output logic                   sod,
    output logic                   eod,
    output logic [7:0]             byte_out
);
    localparam int LANE_W = (KEEP_WIDTH > 1) ? $clog2(KEEP_WIDTH) : 1;
    localparam logic [KEEP_WIDTH-1:0] KEEP_ONE = KEEP_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        SOD,
        STREAM
    } state_t;

    state_t                 state_q;
    logic [DATA_WIDTH-1:0]  word_q;
    logic [KEEP_WIDTH-1:0]  keep_q;      // lanes of the held word not yet emitted
    logic                   last_q;
    logic                   in_pkt_q;
    logic                   live_q;      // holds tready low until the first edge after reset
    logic [NUM_CLASSES-1:0] char_hit_q;
    logic                   en_q;
    logic                   sod_q;
    logic                   eod_q;
    logic [7:0]             byte_q;
    logic [NUM_CLASSES-1:0] table_q [256];

    logic [LANE_W-1:0]      lane_d;
    logic [KEEP_WIDTH-1:0]  keep_d;
    logic                   beat_last_d;
    logic [7:0]             byte_d;
    logic [7:0]             addr_d;
    logic                   accept_d;

    // Pick the lowest remaining kept lane and form the table lookup address
    always_comb begin
        lane_d = '0;
        for (int i = KEEP_WIDTH - 1; i >= 0; i--) begin
            if (keep_q[i]) begin
                lane_d = LANE_W'(i);
            end
        end
        keep_d      = keep_q & (keep_q - KEEP_ONE);
        // Also true for an empty keep mask: a zero-keep word finishes in one cycle.
        beat_last_d = (keep_d == '0);
        byte_d      = word_q[{lane_d, 3'b000} +: 8];
`ifdef PAYLOAD_DEC_NOCASE_EN
        addr_d = ((byte_d >= 8'h41) && (byte_d <= 8'h5A)) ? (byte_d | 8'h20) : byte_d;
`else
        addr_d = byte_d;
`endif
    end

    assign s.tready = live_q && ((state_q == IDLE) || ((state_q == STREAM) && beat_last_d));
    assign accept_d = s.tvalid && s.tready;

    // Class table: programmed by software, read combinationally (old data on a same-cycle write)
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            table_q[cfg_addr] <= cfg_wdata;
        end
    end

    // Holding register payload: captured whenever a word is accepted
    always_ff @(posedge clk) begin
        if (accept_d) begin
            word_q <= s.tdata;
        end
    end

    // Framing FSM with registered engine controls and hit outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            keep_q     <= '0;
            last_q     <= 1'b0;
            in_pkt_q   <= 1'b0;
            live_q     <= 1'b0;
            char_hit_q <= '0;
            en_q       <= 1'b0;
            sod_q      <= 1'b0;
            eod_q      <= 1'b0;
            byte_q     <= '0;
        end else begin
            live_q <= 1'b1;
            en_q   <= 1'b0;
            sod_q  <= 1'b0;
            eod_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        keep_q  <= s.tkeep;
                        last_q  <= s.tlast;
                        state_q <= in_pkt_q ? STREAM : SOD;
                    end
                end
                SOD: begin
                    sod_q    <= 1'b1;
                    in_pkt_q <= 1'b1;
                    state_q  <= STREAM;
                end
                STREAM: begin
                    if (keep_q != '0) begin
                        en_q       <= 1'b1;
                        char_hit_q <= table_q[addr_d];
                        byte_q     <= byte_d;
                    end
                    if (beat_last_d) begin
                        eod_q <= last_q;
                        if (last_q) begin
                            in_pkt_q <= 1'b0;
                        end
                        if (accept_d) begin
                            keep_q  <= s.tkeep;
                            last_q  <= s.tlast;
                            state_q <= (in_pkt_q && !last_q) ? STREAM : SOD;
                        end else begin
                            keep_q  <= '0;
                            state_q <= IDLE;
                        end
                    end else begin
                        keep_q <= keep_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign char_hit = char_hit_q;
    assign en       = en_q;
    assign sod      = sod_q;
    assign eod      = eod_q;
    assign byte_out = byte_q;
endmodule

// File: tb/tb_payload_char_decoder.sv
// tb_payload_char_decoder: directed vectors for framing, lane skipping, zero-keep
// words, back-to-back streaming, mid-packet reset and optional case folding.
module tb_payload_char_decoder;
    localparam int DW = 64;
    localparam int NC = 21;
    localparam int KW = 8;

    localparam logic [NC-1:0] H2  = NC'(1) << 2;
    localparam logic [NC-1:0] H3  = NC'(1) << 3;
    localparam logic [NC-1:0] H14 = NC'(1) << 14;
    localparam logic [NC-1:0] H15 = NC'(1) << 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we;
    logic [7:0]    cfg_addr;
    logic [NC-1:0] cfg_wdata;
    logic [NC-1:0] char_hit;
    logic          en;
    logic          sod;
    logic          eod;
    logic [7:0]    byte_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    payload_char_decoder_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s_if ();

    payload_char_decoder #(
        .DATA_WIDTH (DW),
        .NUM_CLASSES(NC),
        .KEEP_WIDTH (KW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (s_if.slave),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .char_hit (char_hit),
        .en       (en),
        .sod      (sod),
        .eod      (eod),
        .byte_out (byte_out)
    );

    typedef struct packed {
        logic          v;
        logic [63:0]   d;
        logic [7:0]    k;
        logic          l;
        logic          rdy;
        logic          en;
        logic          sod;
        logic          eod;
        logic [NC-1:0] hit;
        logic [7:0]    b;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [63:0] d, logic [7:0] k, logic l,
                                logic rdy, logic e, logic so, logic eo,
                                logic [NC-1:0] hit, logic [7:0] b);
        vec_t r;
        r.v = v; r.d = d; r.k = k; r.l = l;
        r.rdy = rdy; r.en = e; r.sod = so; r.eod = eo; r.hit = hit; r.b = b;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cfg_wr(input logic [7:0] a, input logic [NC-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // Drive up to two words (tvalid held until accepted) and observe the output stream.
    // rst_after > 0 pulses rst_n low once that many bytes have been emitted.
    task automatic run_seq(input logic [63:0] w0, input logic [63:0] w1,
                           input logic [7:0] k0, input logic [7:0] k1,
                           input logic l0, input logic l1, input int nw, input int rst_after,
                           output int n_en, output int n_sod, output int n_eod,
                           output int eod_idx, output int span,
                           output logic [127:0] got, output logic [1:0][NC-1:0] hit);
        int sent;
        int first;
        int last;
        sent = 0; first = -1; last = -1;
        n_en = 0; n_sod = 0; n_eod = 0; eod_idx = -1; span = -1;
        got = '0; hit = '0;
        @(posedge clk); #1;
        for (int c = 0; c < 40; c++) begin
            if (sent < nw) begin
                s_if.tvalid = 1'b1;
                s_if.tdata  = (sent == 0) ? w0 : w1;
                s_if.tkeep  = (sent == 0) ? k0 : k1;
                s_if.tlast  = (sent == 0) ? l0 : l1;
            end else begin
                s_if.tvalid = 1'b0;
            end
            @(negedge clk);
            if (sod) n_sod++;
            if (en) begin
                if (n_en < 16) got[8*n_en +: 8] = byte_out;
                if (n_en < 2) hit[n_en] = char_hit;
                if (first < 0) first = c;
                last = c;
                n_en++;
            end
            if (eod) begin
                n_eod++;
                eod_idx = en ? n_en : 0;
            end
            if (s_if.tvalid && s_if.tready) sent++;
            if (rst_after > 0 && n_en == rst_after) begin
                rst_n = 1'b0;
                #1;
                chk("reset_mid_outputs", {95'd0, s_if.tready, en, sod, eod, char_hit, byte_out}, '0);
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        s_if.tvalid = 1'b0;
        span = last - first;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_en, n_sod, n_eod, eod_idx, span;
        logic [127:0] got;
        logic [1:0][NC-1:0] hit;
        logic [63:0] wa, wb;

        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {95'd0, s_if.tready, en, sod, eod, char_hit, byte_out}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 256; i++) cfg_wr(8'(i), '0);
        cfg_wr(8'h76, H14);
        cfg_wr(8'h61, H15);
        cfg_wr(8'h33, H3);
        cfg_wr(8'h58, H2);

        // "va" single word, tkeep=0x81 sparse word, zero-keep tail word, fresh packet
        vecs.push_back(mk(1, 64'h6176, 8'h03, 1, 1, 0, 0, 0, '0,  8'h00));
        vecs.push_back(mk(0, 64'h0,    8'h00, 0, 0, 0, 0, 0, '0,  8'h00));
        vecs.push_back(mk(0, 64'h0,    8'h00, 0, 0, 0, 1, 0, '0,  8'h00));
        vecs.push_back(mk(0, 64'h0,    8'h00, 0, 1, 1, 0, 0, H14, 8'h76));
        vecs.push_back(mk(0, 64'h0,    8'h00, 0, 1, 1, 0, 1, H15, 8'h61));
        vecs.push_back(mk(0, 64'h0,    8'h00, 0, 1, 0, 0, 0, H15, 8'h61));
        vecs.push_back(mk(1, 64'h7633_3333_3333_3361, 8'h81, 1, 1, 0, 0, 0, H15, 8'h61));
        vecs.push_back(mk(0, 64'h0,    8'h00, 0, 0, 0, 0, 0, H15, 8'h61));
        vecs.push_back(mk(0, 64'h0,    8'h00, 0, 0, 0, 1, 0, H15, 8'h61));
        vecs.push_back(mk(0, 64'h0,    8'h00, 0, 1, 1, 0, 0, H15, 8'h61));
        vecs.push_back(mk(0, 64'h0,    8'h00, 0, 1, 1, 0, 1, H14, 8'h76));
        vecs.push_back(mk(0, 64'h0,    8'h00, 0, 1, 0, 0, 0, H14, 8'h76));
        vecs.push_back(mk(1, 64'h33,   8'h01, 0, 1, 0, 0, 0, H14, 8'h76));
        vecs.push_back(mk(0, 64'h0,    8'h00, 0, 0, 0, 0, 0, H14, 8'h76));
        vecs.push_back(mk(1, 64'h0,    8'h00, 1, 1, 0, 1, 0, H14, 8'h76));
        vecs.push_back(mk(0, 64'h0,    8'h00, 0, 1, 1, 0, 0, H3,  8'h33));
        vecs.push_back(mk(0, 64'h0,    8'h00, 0, 1, 0, 0, 1, H3,  8'h33));
        vecs.push_back(mk(1, 64'h61,   8'h01, 1, 1, 0, 0, 0, H3,  8'h33));
        vecs.push_back(mk(0, 64'h0,    8'h00, 0, 0, 0, 0, 0, H3,  8'h33));
        vecs.push_back(mk(0, 64'h0,    8'h00, 0, 1, 0, 1, 0, H3,  8'h33));
        vecs.push_back(mk(0, 64'h0,    8'h00, 0, 1, 1, 0, 1, H15, 8'h61));
        vecs.push_back(mk(0, 64'h0,    8'h00, 0, 1, 0, 0, 0, H15, 8'h61));

        foreach (vecs[i]) begin
            s_if.tvalid = vecs[i].v;
            s_if.tdata  = vecs[i].d;
            s_if.tkeep  = vecs[i].k;
            s_if.tlast  = vecs[i].l;
            @(negedge clk);
            chk($sformatf("vec%0d {rdy,en,sod,eod,hit,byte}", i),
                {95'd0, s_if.tready, en, sod, eod, char_hit, byte_out},
                {95'd0, vecs[i].rdy, vecs[i].en, vecs[i].sod, vecs[i].eod, vecs[i].hit, vecs[i].b});
            @(posedge clk); #1;
        end
        s_if.tvalid = 1'b0;

        // Two back-to-back full words, tvalid held
        wa = 64'h0807_0605_0403_0201;
        wb = 64'h100F_0E0D_0C0B_0A09;
        run_seq(wa, wb, 8'hFF, 8'hFF, 1'b0, 1'b1, 2, 0, n_en, n_sod, n_eod, eod_idx, span, got, hit);
        chk("b2b_en_count", 128'(n_en), 128'd16);
        chk("b2b_sod_count", 128'(n_sod), 128'd1);
        chk("b2b_eod_count", 128'(n_eod), 128'd1);
        chk("b2b_eod_on_byte", 128'(eod_idx), 128'd16);
        chk("b2b_no_bubble_span", 128'(span), 128'd15);
        chk("b2b_bytes", got, {wb, wa});

        // Reset after 3 of 8 bytes, then a fresh word must restart with sod at its lane 0
        wa = 64'h1817_1615_1413_1211;
        run_seq(wa, wa, 8'hFF, 8'hFF, 1'b0, 1'b0, 1, 3, n_en, n_sod, n_eod, eod_idx, span, got, hit);
        chk("pre_reset_bytes", got[23:0], 128'h131211);
        wa = 64'h2827_2625_2423_2221;
        run_seq(wa, wa, 8'hFF, 8'hFF, 1'b1, 1'b1, 1, 0, n_en, n_sod, n_eod, eod_idx, span, got, hit);
        chk("post_reset_sod_count", 128'(n_sod), 128'd1);
        chk("post_reset_en_count", 128'(n_en), 128'd8);
        chk("post_reset_bytes", got, {64'd0, wa});
        chk("post_reset_eod_on_byte", 128'(eod_idx), 128'd8);

        // Case folding: 'V' (0x56) and 'X' (0x58); table has only lowercase 'v' and raw 'X'
        run_seq(64'h5856, 64'h0, 8'h03, 8'h00, 1'b1, 1'b0, 1, 0, n_en, n_sod, n_eod, eod_idx, span, got, hit);
        chk("fold_bytes_raw", got[15:0], 128'h5856);
`ifdef PAYLOAD_DEC_NOCASE_EN
        chk("fold_hit_V", 128'(hit[0]), 128'(H14));
        chk("fold_hit_X", 128'(hit[1]), 128'd0);
`else
        chk("fold_hit_V", 128'(hit[0]), 128'd0);
        chk("fold_hit_X", 128'(hit[1]), 128'(H2));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
